// File: rtl/ic_bvuge_bvlshr0_sweep_checker_if.sv
// Request/response bus between the sweep checker and the Skolem witness block.
//   req_valid/req_ready : handshake for one (s,t) pair
//   req_s, req_t        : operands of the pair being requested
//   rsp_valid, rsp_x    : witness x returned for the last accepted pair
// master = sweep checker side, slave = witness block side.
interface ic_bvuge_bvlshr0_sweep_checker_if #(
   parameter int W = 4
);
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] req_s;
   logic [W-1:0] req_t;
   logic         rsp_valid;
   logic [W-1:0] rsp_x;

   modport master (
      output req_valid, req_s, req_t,
      input  req_ready, rsp_valid, rsp_x
   );

   modport slave (
      input  req_valid, req_s, req_t,
      output req_ready, rsp_valid, rsp_x
   );
endinterface

// File: rtl/ic_bvuge_bvlshr0_sweep_checker.sv
// Sweep checker for the bvuge/bvlshr0 witness: (x >>u s) >=u t.
// Walks every (s,t) pair, requests a witness x for each one and flags pairs where
// the invertibility condition holds but the returned witness does not satisfy it.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a sweep (honoured in IDLE or DONE only)
//   bus               request/response bus (master side)
//   busy              sweep in progress (ISSUE/WAIT/CHECK)
//   done              sweep finished or aborted; held until next start
//   pass              done with no failures and no timeout
//   fail_cnt          failing pairs, saturating
//   first_fail_*      first failing pair of this sweep
//   timeout_err       sweep aborted waiting for rsp_valid
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_ISSUE | req_valid high, pair idx offered to witness block
// S_WAIT  | request accepted, waiting for rsp_valid (timed)
// S_CHECK | evaluate captured witness, advance idx
// S_DONE  | sweep over, results held until start
module ic_bvuge_bvlshr0_sweep_checker #(
   parameter int W       = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   ic_bvuge_bvlshr0_sweep_checker_if.master     bus,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 pass,
   output logic [2*W:0]                         fail_cnt,
   output logic                                 first_fail_valid,
   output logic [W-1:0]                         first_fail_s,
   output logic [W-1:0]                         first_fail_t,
   output logic                                 timeout_err
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [2*W-1:0]  idx;
   logic [TW-1:0]   timer;
   logic [W-1:0]    x_q;
   logic            last_pair;
   logic            timer_tc;
   logic            pair_fail;
   logic [W-1:0]    cur_s;
   logic [W-1:0]    cur_t;

   // Logical right shift where any amount >= W clears the result.
   function automatic logic [W-1:0] lshr(input logic [W-1:0] a, input logic [W-1:0] sh);
      if (int'(sh) >= W) return '0;
      return a >> sh;
   endfunction

   assign cur_s     = idx[2*W-1:W];
   assign cur_t     = idx[W-1:0];
   assign last_pair = (idx == '1);
   // Down-counter loaded with TIMEOUT-1 at the handshake; reaching zero while
   // still in WAIT means TIMEOUT cycles have elapsed without a response.
   assign timer_tc  = (timer == '0);
   assign pair_fail = (lshr('1, cur_s) >= cur_t) && !(lshr(x_q, cur_s) >= cur_t);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_ISSUE;
         S_ISSUE:        if (bus.req_ready) state_nxt = S_WAIT;
         S_WAIT: begin
            if (bus.rsp_valid)  state_nxt = S_CHECK;
            else if (timer_tc)  state_nxt = S_DONE;
         end
         S_CHECK:        state_nxt = last_pair ? S_DONE : S_ISSUE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_valid = (state == S_ISSUE);
      bus.req_s     = cur_s;
      bus.req_t     = cur_t;
      busy          = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
   end

   assign pass = done && (fail_cnt == '0) && !timeout_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx              <= '0;
         timer            <= '0;
         x_q              <= '0;
         fail_cnt         <= '0;
         first_fail_valid <= 1'b0;
         first_fail_s     <= '0;
         first_fail_t     <= '0;
         timeout_err      <= 1'b0;
         done             <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  idx              <= '0;
                  fail_cnt         <= '0;
                  first_fail_valid <= 1'b0;
                  first_fail_s     <= '0;
                  first_fail_t     <= '0;
                  timeout_err      <= 1'b0;
                  done             <= 1'b0;
               end
            end
            S_ISSUE: begin
               if (bus.req_ready) timer <= TW'(TIMEOUT - 1);
            end
            S_WAIT: begin
               if (bus.rsp_valid) begin
                  x_q <= bus.rsp_x;
               end else if (timer_tc) begin
                  timeout_err <= 1'b1;
                  done        <= 1'b1;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_CHECK: begin
               if (pair_fail) begin
                  if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                  if (!first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_s     <= cur_s;
                     first_fail_t     <= cur_t;
                  end
               end
               if (last_pair) done <= 1'b1;
               else           idx  <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ic_bvuge_bvlshr0_sweep_checker.sv
module tb_ic_bvuge_bvlshr0_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start2, start4;

   ic_bvuge_bvlshr0_sweep_checker_if #(.W(2)) bus2 ();
   ic_bvuge_bvlshr0_sweep_checker_if #(.W(4)) bus4 ();

   logic       busy2, done2, pass2, ffv2, tmo2;
   logic [4:0] fail_cnt2;
   logic [1:0] ffs2, fft2;

   logic       busy4, done4, pass4, ffv4, tmo4;
   logic [8:0] fail_cnt4;
   logic [3:0] ffs4, fft4;

   ic_bvuge_bvlshr0_sweep_checker #(.W(2), .TIMEOUT(16)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .bus(bus2.master),
      .busy(busy2), .done(done2), .pass(pass2), .fail_cnt(fail_cnt2),
      .first_fail_valid(ffv2), .first_fail_s(ffs2), .first_fail_t(fft2),
      .timeout_err(tmo2)
   );

   ic_bvuge_bvlshr0_sweep_checker #(.W(4), .TIMEOUT(16)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .bus(bus4.master),
      .busy(busy4), .done(done4), .pass(pass4), .fail_cnt(fail_cnt4),
      .first_fail_valid(ffv4), .first_fail_s(ffs4), .first_fail_t(fft4),
      .timeout_err(tmo4)
   );

   int checks = 0;
   int errors = 0;

   // W=2 responder: answers one cycle after each handshake.
   // rsp_mode 0: x=2'b11, 1: x=0, 2: never responds.
   int rsp_mode   = 0;
   int stall_left = 0;
   bit hs2_prev   = 1'b0;
   always @(negedge clk) begin
      if (stall_left > 0 && bus2.req_valid && bus2.req_s == 2'd1 && bus2.req_t == 2'd2) begin
         bus2.req_ready = 1'b0;
         stall_left--;
      end else begin
         bus2.req_ready = 1'b1;
      end
      bus2.rsp_valid = hs2_prev && (rsp_mode != 2);
      bus2.rsp_x     = (rsp_mode == 0) ? 2'b11 : 2'b00;
      hs2_prev       = bus2.req_valid && bus2.req_ready;
   end

   // W=4 responder: random ready stalls, x = all ones, records accepted pairs.
   bit hs4_prev = 1'b0;
   bit rec4     = 1'b0;
   int issued4[$];
   always @(negedge clk) begin
      bus4.req_ready = ($urandom_range(0, 3) != 0);
      bus4.rsp_valid = hs4_prev;
      bus4.rsp_x     = 4'hF;
      hs4_prev       = bus4.req_valid && bus4.req_ready;
      if (hs4_prev && rec4) issued4.push_back(int'({bus4.req_s, bus4.req_t}));
   end

   // Pulses start2 and counts cycles from the start edge until done2.
   // first_st is {req_valid, req_s, req_t} right after the start edge.
   task automatic sweep2(input int mid_start, output int cyc, output logic [4:0] first_st);
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2   = 1'b0;
      first_st = {bus2.req_valid, bus2.req_s, bus2.req_t};
      cyc = 0;
      while (!done2 && cyc < 300) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         start2 = (cyc == mid_start);
      end
      start2 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start2 = 1'b0; start4 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy2, done2, pass2, ffv2, tmo2, bus2.req_valid, bus2.req_s, bus2.req_t,
           fail_cnt2, ffs2, fft2} !== 19'd0) begin
         errors++;
         $display("FAIL reset_w2: outputs=%h required 0", {busy2, done2, pass2, ffv2, tmo2,
                  bus2.req_valid, bus2.req_s, bus2.req_t, fail_cnt2, ffs2, fft2});
      end
      checks++;
      if ({busy4, done4, pass4, ffv4, tmo4, bus4.req_valid, bus4.req_s, bus4.req_t,
           fail_cnt4, ffs4, fft4} !== 31'd0) begin
         errors++;
         $display("FAIL reset_w4: outputs=%h required 0", {busy4, done4, pass4, ffv4, tmo4,
                  bus4.req_valid, bus4.req_s, bus4.req_t, fail_cnt4, ffs4, fft4});
      end
      rst = 1'b0;
   endtask

   task automatic test_pass_ones;
      int cyc;
      logic [4:0] fst;
      rsp_mode = 0;
      sweep2(-1, cyc, fst);
      checks++;
      if (cyc !== 48) begin errors++; $display("FAIL ones_latency: got %0d required 48", cyc); end
      checks++;
      if ({pass2, ffv2, tmo2, fail_cnt2} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
         errors++;
         $display("FAIL ones_result: pass=%b ffv=%b tmo=%b fail_cnt=%0d required 1 0 0 0",
                  pass2, ffv2, tmo2, fail_cnt2);
      end
   endtask

   task automatic test_fail_zero;
      int cyc;
      logic [4:0] fst;
      rsp_mode = 1;
      sweep2(-1, cyc, fst);
      checks++;
      if (fail_cnt2 !== 5'd4) begin errors++; $display("FAIL zero_fail_cnt: got %0d required 4", fail_cnt2); end
      checks++;
      if ({ffv2, ffs2, fft2} !== {1'b1, 2'd0, 2'd1}) begin
         errors++;
         $display("FAIL zero_first_fail: valid=%b s=%0d t=%0d required 1 0 1", ffv2, ffs2, fft2);
      end
      checks++;
      if ({done2, pass2} !== 2'b10) begin errors++; $display("FAIL zero_pass: done=%b pass=%b required 1 0", done2, pass2); end
   endtask

   task automatic test_timeout;
      int n;
      rsp_mode = 2;
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      #1;
      n = 0;
      while (!(bus2.req_valid && bus2.req_ready) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      @(posedge clk);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!done2 && n < 100);
      checks++;
      if (n !== 16) begin errors++; $display("FAIL timeout_latency: got %0d required 16", n); end
      checks++;
      if ({tmo2, done2, pass2, fail_cnt2} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin
         errors++;
         $display("FAIL timeout_result: tmo=%b done=%b pass=%b fail_cnt=%0d required 1 1 0 0",
                  tmo2, done2, pass2, fail_cnt2);
      end
      rsp_mode = 0;
   endtask

   task automatic test_stall;
      int cyc;
      int n;
      logic [4:0] fst;
      rsp_mode   = 0;
      stall_left = 5;
      fork
         sweep2(-1, cyc, fst);
         begin
            n = 0;
            @(negedge clk);
            while (!(bus2.req_valid && bus2.req_s == 2'd1 && bus2.req_t == 2'd2) && n < 200) begin
               @(negedge clk); n++;
            end
            for (int i = 0; i < 5; i++) begin
               checks++;
               if ({bus2.req_valid, bus2.req_s, bus2.req_t} !== 5'b1_01_10) begin
                  errors++;
                  $display("FAIL stall_hold[%0d]: valid,s,t=%b required 10110", i,
                           {bus2.req_valid, bus2.req_s, bus2.req_t});
               end
               @(negedge clk);
            end
         end
      join
      checks++;
      if (cyc !== 53) begin errors++; $display("FAIL stall_latency: got %0d required 53", cyc); end
      checks++;
      if ({pass2, ffv2, fail_cnt2} !== {1'b1, 1'b0, 5'd0}) begin
         errors++;
         $display("FAIL stall_result: pass=%b ffv=%b fail_cnt=%0d required 1 0 0", pass2, ffv2, fail_cnt2);
      end
      stall_left = 0;
   endtask

   task automatic test_reset_mid;
      int n;
      int cyc;
      logic [4:0] fst;
      rsp_mode = 0;
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      #1;
      n = 0;
      while (!(bus2.req_valid && bus2.req_ready && bus2.req_s == 2'd2 && bus2.req_t == 2'd1) && n < 100) begin
         @(negedge clk); #1; n++;
      end
      @(negedge clk);
      checks++;
      if ({busy2, bus2.req_valid} !== 2'b10) begin
         errors++;
         $display("FAIL mid_in_wait: busy=%b req_valid=%b required 1 0", busy2, bus2.req_valid);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy2, done2, bus2.req_valid, bus2.req_s, bus2.req_t} !== 7'd0) begin
         errors++;
         $display("FAIL mid_reset_idle: busy=%b done=%b valid=%b s=%0d t=%0d required all 0",
                  busy2, done2, bus2.req_valid, bus2.req_s, bus2.req_t);
      end
      sweep2(20, cyc, fst);
      checks++;
      if (fst !== 5'b1_00_00) begin errors++; $display("FAIL restart_idx0: valid,s,t=%b required 10000", fst); end
      checks++;
      if (cyc !== 48) begin errors++; $display("FAIL mid_start_ignored: latency %0d required 48", cyc); end
      checks++;
      if ({pass2, fail_cnt2} !== {1'b1, 5'd0}) begin
         errors++;
         $display("FAIL restart_result: pass=%b fail_cnt=%0d required 1 0", pass2, fail_cnt2);
      end
   endtask

   task automatic test_w4_sweep;
      int n;
      int bad;
      issued4.delete();
      rec4 = 1'b1;
      @(negedge clk);
      start4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 5000) begin
         @(negedge clk); n++;
      end
      rec4 = 1'b0;
      checks++;
      if ({done4, pass4, tmo4, fail_cnt4} !== {1'b1, 1'b1, 1'b0, 9'd0}) begin
         errors++;
         $display("FAIL w4_result: done=%b pass=%b tmo=%b fail_cnt=%0d required 1 1 0 0",
                  done4, pass4, tmo4, fail_cnt4);
      end
      checks++;
      if (issued4.size() !== 256) begin
         errors++;
         $display("FAIL w4_issue_count: got %0d required 256", issued4.size());
      end
      bad = -1;
      foreach (issued4[i]) if (bad < 0 && issued4[i] != i) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL w4_issue_order: entry %0d is %0d required %0d", bad, issued4[bad], bad);
      end
   endtask

   initial begin
      test_reset();
      test_pass_ones();
      test_fail_zero();
      test_timeout();
      test_stall();
      test_reset_mid();
      test_w4_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
